// File: rtl/altera_ram_pkg.sv
// Shared sizing for the 16 KB byte RAM behind the Wishbone 32-to-8 bridge.
package altera_ram_pkg;

  localparam int RAM_ADDR_WIDTH = 14;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_DEPTH      = 1 << RAM_ADDR_WIDTH;

  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0] ram_data_t;

  // The bridge hands over wider byte addresses; only the low bits select a location.
  function automatic ram_addr_t ram_wrap(input logic [31:0] byte_addr);
    return byte_addr[RAM_ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/altera_ram_if.sv
// Byte-access port between the 32-to-8 bridge (master) and the RAM (slave).
interface altera_ram_if
  import altera_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output address,
    output data,
    output wren,
    input  q
  );

  modport slave (
    input  address,
    input  data,
    input  wren,
    output q
  );

endinterface

// File: rtl/altera_ram_array.sv
// Bare single-port byte array: write port plus registered, write-through read port.
module altera_ram_array
  import altera_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Contents survive reset; only the output register is cleared.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge wb_clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Same-address read during a write returns the data being written.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      q <= '0;
    end else begin
      q <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/altera_ram.sv
// 16 KB single-port byte RAM: input register stage in front of the array, 2-cycle read latency.
module altera_ram
  import altera_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  altera_ram_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  wren_r;

  // The bridge updates these on the falling edge, so they are stable here.
  // Clearing wren_r on reset drops any write not yet committed to the array.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr_r <= '0;
      data_r <= '0;
      wren_r <= 1'b0;
    end else begin
      addr_r <= bus.address;
      data_r <= bus.data;
      wren_r <= bus.wren;
    end
  end

  altera_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .addr     (addr_r),
    .wdata    (data_r),
    .we       (wren_r),
    .q        (bus.q)
  );

endmodule

// File: tb/tb_altera_ram.sv
// Self-checking bench for altera_ram: directed scenarios plus random traffic, scoreboard-checked.
module tb_altera_ram;

  logic clk;
  logic rst;
  bit   issue;
  int   n_vec;
  int   n_err;

  altera_ram_if bus ();

  altera_ram dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain byte array updated in program order, plus a written-location map.
  logic [7:0]  mdl   [0:16383];
  bit          known [0:16383];
  logic [7:0]  exp_q  [$];
  logic [13:0] addr_q [$];

  // Every access returns a byte two edges later: stored data for a read, new data for a write.
  task automatic drive(input logic w, input logic [13:0] a, input logic [7:0] d, input bit chk);
    @(negedge clk);
    bus.wren    = w;
    bus.address = a;
    bus.data    = d;
    if (w) begin
      mdl[a]   = d;
      known[a] = 1'b1;
    end
    issue = chk && known[a];
    if (issue) begin
      exp_q.push_back(mdl[a]);
      addr_q.push_back(a);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, got, want);
    end
  endtask

  // Monitor: tracks which cycles carried a checked access and compares q two edges later.
  initial begin
    bit p1, p2;
    logic [7:0]  e;
    logic [13:0] a;
    p1 = 1'b0;
    p2 = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        p1 = 1'b0;
        p2 = 1'b0;
      end else begin
        p2 = p1;
        p1 = issue;
      end
      @(negedge clk);
      if (p2 && !rst) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_underflow: q=%02h with nothing expected", bus.q);
        end else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          if (bus.q !== e) begin
            n_err++;
            $display("FAIL read_q addr=%04h: got %02h, expected %02h", a, bus.q, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    issue       = 1'b0;
    rst         = 1'b1;
    bus.wren    = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    for (int i = 0; i < 16384; i++) known[i] = 1'b0;

    repeat (3) @(negedge clk);
    #1 check_val("reset_q", bus.q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read at both ends of the address space.
    drive(1'b1, 14'h0000, 8'hA5, 1'b1);
    drive(1'b1, 14'h3FFF, 8'h5A, 1'b1);
    drive(1'b0, 14'h3FFF, 8'h00, 1'b1);
    drive(1'b0, 14'h0000, 8'h00, 1'b1);

    // Pipelined writes then back-to-back reads; also seed 0x0300 for the reset scenario.
    for (int i = 0; i < 4; i++) drive(1'b1, 14'h0100 + 14'(i), 8'(8'h11 * (i + 1)), 1'b1);
    drive(1'b1, 14'h0300, 8'h5C, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 14'h0100 + 14'(i), 8'h00, 1'b1);

    // Write enable low: data bus activity must not disturb the array.
    for (int i = 0; i < 3; i++) drive(1'b0, 14'h0100, 8'hFF, 1'b1);
    drive(1'b0, 14'h0100, 8'h00, 1'b1);

    // Read-during-write at the same address.
    drive(1'b1, 14'h0200, 8'h77, 1'b1);
    drive(1'b0, 14'h0200, 8'h00, 1'b1);

    // Reset while a write of 0xEE is captured but not yet committed.
    drive(1'b0, 14'h0100, 8'h00, 1'b1);
    @(negedge clk);
    bus.wren    = 1'b1;
    bus.address = 14'h0300;
    bus.data    = 8'hEE;
    issue       = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_val("reset_async_q", bus.q, 8'h00);
    bus.wren = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 14'h0300, 8'h00, 1'b1);
    drive(1'b0, 14'h0100, 8'h00, 1'b1);

    // Address boundary, back-to-back writes then reads.
    drive(1'b1, 14'h3FFF, 8'hC3, 1'b1);
    drive(1'b1, 14'h0000, 8'h3C, 1'b1);
    drive(1'b0, 14'h3FFF, 8'h00, 1'b1);
    drive(1'b0, 14'h0000, 8'h00, 1'b1);

    // Random traffic over a seeded window plus the two extreme addresses.
    for (int i = 0; i < 64; i++) drive(1'b1, 14'h2000 + 14'(i), 8'($urandom), 1'b1);
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [13:0] a;
      sel = $urandom_range(0, 65);
      if (sel == 64)      a = 14'h0000;
      else if (sel == 65) a = 14'h3FFF;
      else                a = 14'h2000 + 14'(sel);
      drive(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b1);
    end

    // Drain the pipeline and make sure every expected result was seen.
    for (int i = 0; i < 4; i++) drive(1'b0, 14'h0000, 8'h00, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
